mux_sel_pipe: RTL and testbench
===============================

# mux_sel_pipe

Parametrised, registered N-way selector with a valid/ready handshake, the pipelined successor of the fixed 5-bit two-input register-destination mux used in the single-cycle datapath. It selects one of `NUM_IN` operands of `WIDTH` bits, registers the result, and absorbs downstream back-pressure with an optional skid entry. It flags out-of-range selects. It sits between decode and the register-file write-address stage of the pipelined core.

## Interface
Parameters:
- `WIDTH`, 5, data width of each input and of the output
- `NUM_IN`, 2, number of inputs; must be 2 or more
- `SEL_W`, 1, select width; must satisfy 2^`SEL_W` >= `NUM_IN`

Ports:
- `clk`  input  1  the single clock; all state updates on the rising edge
- `rst`  input  1  asynchronous, active-high reset
- `in_data`  input  `NUM_IN*WIDTH`  flattened operands; input k occupies bits [k*WIDTH +: WIDTH]
- `sel`  input  `SEL_W`  operand index; sampled with `in_data` on accept
- `in_valid`  input  1  upstream presents `in_data` and `sel`
- `in_ready`  output  1  block can accept this cycle
- `out_data`  output  `WIDTH`  registered selected operand
- `out_valid`  output  1  `out_data` is valid
- `out_ready`  input  1  downstream accepts `out_data`
- `err_clr`  input  1  clears `sel_err`
- `sel_err`  output  1  sticky flag, set when a select is out of range

## Operation
- in_fire = `in_valid` & `in_ready`; out_fire = `out_valid` & `out_ready`.
- Selected value: input[`sel`] when `sel` < `NUM_IN`. When `sel` >= `NUM_IN`, the value is all zeros and `sel_err` is set on that accept.
- State: main register (`out_data`, `out_valid`) and, when configured, one skid entry (skid_data, skid_valid).
- Main register loads when `out_valid` = 0 or on out_fire:
  - from the skid entry if skid_valid = 1; skid_valid then clears in the same edge;
  - otherwise from the selected value if in_fire;
  - otherwise `out_valid` goes to 0.
- Skid entry loads on in_fire when `out_valid` = 1 and `out_ready` = 0.
- `in_ready` = !skid_valid. It is a register output and has no combinational path from `out_ready`.
- In-order delivery; no value is dropped or duplicated.
- `sel_err` is set on an accept with an out-of-range `sel`. It is cleared by `err_clr`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, skid_valid = 0, skid_data = 0, `sel_err` = 0, `in_ready` = 1 in skid mode.
- Latency: 1 cycle. An input accepted at edge n appears on `out_data` and `out_valid` after edge n.
- Throughput: 1 transfer per cycle while `out_ready` = 1.
- Stall: when `out_ready` falls with `out_valid` = 1, one more input is accepted into the skid entry. `in_ready` is then 0 from the next cycle.
- Release: on the first out_fire after a stall, the skid entry moves to the main register. `in_ready` returns to 1 in the following cycle.
- In skid mode, in_fire and a non-empty skid entry never coincide, because `in_ready` = 0 while the skid entry is full.
- `rst` asserted mid-transfer clears all contents immediately, including a pending skid entry. The first accept after reset deassertion behaves as from empty.
- `out_data` holds its value while `out_valid` = 1 and `out_ready` = 0.

## Configuration
- `MUX_SEL_PIPE_SKID_EN` defined:
  - skid entry present;
  - `in_ready` is registered, as described above.
- Not defined:
  - no skid entry;
  - `in_ready` = !`out_valid` | `out_ready`, a combinational path from `out_ready`;
  - latency is still 1 cycle and throughput still 1 per cycle;
  - in reset, `in_ready` = 1 because `out_valid` = 0.

## Test plan
- `WIDTH`=5, `NUM_IN`=2, inputs {A=0, B=5'b11111}, `sel`=1, `in_valid`=1, `out_ready`=1 -> one cycle later `out_data`=5'b11111, `out_valid`=1, `sel_err`=0.
- `WIDTH`=8, `NUM_IN`=3, stream `sel`=0,1,2 with inputs 0x11/0x22/0x33, `out_ready`=1 -> outputs 0x11, 0x22, 0x33 on three consecutive cycles.
- Same config, `sel`=3 accepted -> `out_data`=0x00 and `sel_err`=1 stays high; pulse `err_clr` -> `sel_err`=0; `err_clr` in the same cycle as another `sel`=3 accept -> `sel_err` stays 1.
- Skid mode, stream 0x01,0x02,0x03, `out_ready` low for 3 cycles after 0x01 is output -> 0x02 is held in the skid entry, `in_ready`=0, 0x03 is held upstream; releasing `out_ready` yields 0x01, 0x02, 0x03 in order with no loss.
- Assert `rst` while the skid entry is full -> immediately `out_valid`=0, `out_data`=0, `in_ready`=1; no stale value is output after reset is released.
- No-skid build, `out_valid`=1 and `out_ready`=0 -> `in_ready`=0 in the same cycle; raise `out_ready` -> `in_ready`=1 combinationally and a new accept occurs that edge.

Source files
------------

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N-way selector with a valid/ready handshake.
// Selects one of NUM_IN operands of WIDTH bits by `sel`, registers the result,
// and flags out-of-range selects with a sticky error bit.
//
// Optional feature macro: MUX_SEL_PIPE_SKID_EN
//   defined     -> one skid entry absorbs back-pressure; in_ready = !skid_valid
//                  (register-driven, no combinational path from out_ready)
//   not defined -> no skid entry; in_ready = !out_valid | out_ready
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    flattened operands, input k at [k*WIDTH +: WIDTH]
//   sel        operand index, sampled with in_data on accept
//   in_valid   upstream offers in_data/sel
//   in_ready   block can accept this cycle
//   out_data   registered selected operand
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
//   err_clr    clears sel_err (a same-cycle set wins)
//   sel_err    sticky out-of-range select flag
module mux_sel_pipe #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic                    sel_err
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
`ifdef MUX_SEL_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
`endif

  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic             in_fire;
  logic             load_main;

  // Operand select; out-of-range indices yield zero and sel_ok = 0
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

`ifdef MUX_SEL_PIPE_SKID_EN
  assign in_ready = !skid_valid_q;
`else
  assign in_ready = !out_valid_q | out_ready;
`endif

  assign in_fire   = in_valid & in_ready;
  assign load_main = !out_valid_q | out_ready;

  // Next-state for main register, skid entry and error flag
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
`ifdef MUX_SEL_PIPE_SKID_EN
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;

    if (load_main) begin
      if (skid_valid_q) begin
        // Skid entry is older than anything upstream, so it drains first
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_data_d  = sel_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // Catch the one beat accepted while the output is stalling
    if (in_fire && out_valid_q && !out_ready) begin
      skid_data_d  = sel_data;
      skid_valid_d = 1'b1;
    end
`else
    if (load_main) begin
      if (in_fire) begin
        out_data_d  = sel_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
`endif

    // Set has priority over clear
    if (err_clr) sel_err_d = 1'b0;
    if (in_fire && !sel_ok) sel_err_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      sel_err_q    <= 1'b0;
`ifdef MUX_SEL_PIPE_SKID_EN
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
`endif
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      sel_err_q    <= sel_err_d;
`ifdef MUX_SEL_PIPE_SKID_EN
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe: an 8-bit/3-input instance carries the
// vector table, stall stream and reset-while-stalled cases; a 5-bit/2-input
// instance covers the legacy register-destination configuration.
module tb_mux_sel_pipe;

`ifdef MUX_SEL_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit, 3-input instance
  logic [23:0] d8;
  logic [1:0]  s8;
  logic        v8, rdy8, ov8, ordy8, clr8, err8;
  logic [7:0]  od8;

  // 5-bit, 2-input instance
  logic [9:0]  d5;
  logic        s5, v5, rdy5, ov5, ordy5, clr5, err5;
  logic [4:0]  od5;

  mux_sel_pipe #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_data(d8), .sel(s8), .in_valid(v8),
    .in_ready(rdy8), .out_data(od8), .out_valid(ov8), .out_ready(ordy8),
    .err_clr(clr8), .sel_err(err8)
  );

  mux_sel_pipe #(.WIDTH(5), .NUM_IN(2), .SEL_W(1)) u_dut5 (
    .clk(clk), .rst(rst), .in_data(d5), .sel(s5), .in_valid(v5),
    .in_ready(rdy5), .out_data(od5), .out_valid(ov5), .out_ready(ordy5),
    .err_clr(clr5), .sel_err(err5)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic       clr;
    logic [7:0] a, b, c;
    logic [7:0] exp_d;
    logic       exp_v;
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];

  logic [7:0] src[3];
  logic [7:0] rcv[$];
  int         idx;
  logic       fin;

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 1'b0, 8'h11, 8'h22, 8'h33, 8'h11, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 8'h11, 8'h22, 8'h33, 8'h22, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 8'h11, 8'h22, 8'h33, 8'h33, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 8'h11, 8'h22, 8'h33, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'd3, 1'b0, 8'h11, 8'h22, 8'h33, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 2'd3, 1'b0, 8'h11, 8'h22, 8'h33, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 8'h11, 8'h22, 8'h33, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 8'h11, 8'h22, 8'h33, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'd3, 1'b1, 8'h11, 8'h22, 8'h33, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 8'h44, 8'h55, 8'h66, 8'h55, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 8'h44, 8'h55, 8'h66, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 8'ha5, 8'h5a, 8'hc3, 8'hc3, 1'b1, 1'b0};

    d8 = '0; s8 = '0; v8 = 1'b0; ordy8 = 1'b1; clr8 = 1'b0;
    d5 = '0; s5 = 1'b0; v5 = 1'b0; ordy5 = 1'b1; clr5 = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_out_data",  32'(od8), 32'd0);
    chk("rst_sel_err",   32'(err8), 32'd0);
    chk("rst_in_ready",  32'(rdy8), 32'd1);
    chk("rst5_out_data", 32'(od5), 32'd0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // Legacy 5-bit, 2-input configuration
    v5 = 1'b1; s5 = 1'b1; d5 = {5'b11111, 5'b00000};
    @(posedge clk); #1;
    chk("w5_sel1_data",  32'(od5), 32'h1f);
    chk("w5_sel1_valid", 32'(ov5), 32'd1);
    chk("w5_sel1_err",   32'(err5), 32'd0);
    s5 = 1'b0;
    @(posedge clk); #1;
    chk("w5_sel0_data",  32'(od5), 32'h00);
    v5 = 1'b0;

    // Vector table, out_ready held high
    for (int i = 0; i < 12; i++) begin
      v8 = vecs[i].v; s8 = vecs[i].sel; clr8 = vecs[i].clr;
      d8 = {vecs[i].c, vecs[i].b, vecs[i].a}; ordy8 = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(ov8), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v) chk($sformatf("vec%0d_data", i), 32'(od8), 32'(vecs[i].exp_d));
      chk($sformatf("vec%0d_err", i), 32'(err8), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ready", i), 32'(rdy8), 32'd1);
    end

    // Drain
    v8 = 1'b0; clr8 = 1'b0; ordy8 = 1'b1;
    @(posedge clk); #1;
    chk("drain_valid", 32'(ov8), 32'd0);

    // Stall stream: out_ready low for three cycles after 0x01 is output
    src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03;
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      ordy8 = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
      v8    = (idx < 3);
      s8    = 2'd0;
      d8    = {16'h0000, (idx < 3) ? src[idx] : 8'h00};
      #1;
      fin = v8 & rdy8;
      if (ov8 & ordy8) rcv.push_back(od8);
      case (c)
        1: begin
          chk("stall_c1_ready", 32'(rdy8), SKID ? 32'd1 : 32'd0);
          chk("stall_c1_data",  32'(od8), 32'h01);
        end
        2: chk("stall_c2_ready", 32'(rdy8), 32'd0);
        3: begin
          chk("stall_hold_data",  32'(od8), 32'h01);
          chk("stall_hold_valid", 32'(ov8), 32'd1);
        end
        4: chk("release_c4_ready", 32'(rdy8), SKID ? 32'd0 : 32'd1);
        5: chk("release_c5_ready", 32'(rdy8), 32'd1);
        default: ;
      endcase
      @(posedge clk); #1;
      if (fin) idx++;
    end
    chk("stream_accepts", 32'(idx), 32'd3);
    chk("stream_count", 32'(rcv.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < rcv.size()) chk($sformatf("stream_order%0d", k), 32'(rcv[k]), 32'(src[k]));

    // Reset while stalled (skid entry full in the skid build)
    v8 = 1'b1; s8 = 2'd0; d8 = {16'h0000, 8'h0a}; ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0; d8 = {16'h0000, 8'h0b};
    @(posedge clk); #1;
    chk("pre_rst_data", 32'(od8), 32'h0a);
    #2 rst = 1'b1; v8 = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ov8), 32'd0);
    chk("mid_rst_data",  32'(od8), 32'd0);
    chk("mid_rst_ready", 32'(rdy8), 32'd1);
    @(negedge clk); rst = 1'b0;
    ordy8 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_idle%0d", c), 32'(ov8), 32'd0);
    end
    v8 = 1'b1; s8 = 2'd2; d8 = {8'h77, 8'h66, 8'h55};
    @(posedge clk); #1;
    chk("post_rst_data",  32'(od8), 32'h77);
    chk("post_rst_valid", 32'(ov8), 32'd1);
    v8 = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
